multi_debouncer: RTL

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/tick_gen.sv | 38 +++
 rtl/multi_debouncer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the multi-channel switch debouncer.
//   - db_state_t     : per-channel debounce FSM state
//   - state_is_high  : debounced level associated with a state
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,   // debounced low, input agrees
        WAIT1 = 2'd1,   // debounced low, input high, counting ticks
        ONE   = 2'd2,   // debounced high, input agrees
        WAIT0 = 2'd3    // debounced high, input low, counting ticks
    } db_state_t;

    // The debounced output is high in ONE and in WAIT0: a WAIT state keeps
    // the level of the state it came from until the change is confirmed.
    function automatic logic state_is_high(db_state_t st);
        return (st == ONE) || (st == WAIT0);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running sample tick: counts 0..M-1 and wraps to 0. max_tick is high
//   for the single cycle in which the count equals M-1, i.e. once every M
//   cycles. The count restarts from 0 when reset is released.
//
//   Ports:
//     clk      in   system clock, rising edge
//     reset    in   asynchronous, active-high
//     max_tick out  1-cycle pulse every M clk cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int M = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // Count is 0 in reset and M >= 2, so the tick is low during reset.
    assign max_tick = (cnt == LAST);

endmodule

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   N independent switch debouncers sharing one sample tick. Each raw input
//   is synchronised through two flops; a per-channel FSM changes the
//   debounced level only after the synchronised input has held the opposite
//   level for STABLE consecutive ticks. Any reversal during the wait aborts
//   it without touching the output.
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-high
//     sw     in   [N] raw asynchronous switch levels
//     db     out  [N] registered debounced levels
//     rise   out  [N] 1-cycle pulse in the first cycle db[i] reads 1
//     fall   out  [N] 1-cycle pulse in the first cycle db[i] reads 0
// -----------------------------------------------------------------------------
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N        = 4,
    parameter int TICK_CNT = 1_000_000,
    parameter int STABLE   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw,
    output logic [N-1:0] db,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [N-1:0] sw_meta;
    logic [N-1:0] s;
    logic         tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            s       <= '0;
        end else begin
            sw_meta <= sw;
            s       <= sw_meta;
        end
    end

    tick_gen #(
        .M(TICK_CNT)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .max_tick(tick)
    );

    for (genvar i = 0; i < N; i++) begin : g_ch
        db_state_t     state;
        db_state_t     state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          db_nxt;
        logic          rise_nxt;
        logic          fall_nxt;
        logic          db_q;
        logic          rise_q;
        logic          fall_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state  <= ZERO;
                cnt    <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                db_q   <= db_nxt;
                rise_q <= rise_nxt;
                fall_q <= fall_nxt;
            end
        end

        // A level reversal is checked before the tick, so a reversal that
        // coincides with a tick returns to the origin state uncounted.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ZERO: begin
                    if (s[i]) begin
                        state_nxt = WAIT1;
                        cnt_nxt   = '0;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_nxt = ZERO;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) state_nxt = ONE;
                        else                 cnt_nxt   = cnt + CW'(1);
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_nxt = WAIT0;
                        cnt_nxt   = '0;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_nxt = ONE;
                    end else if (tick) begin
                        if (cnt == CNT_LAST) state_nxt = ZERO;
                        else                 cnt_nxt   = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = ZERO;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered alongside
        // it, so db changes on the same edge as the confirming transition
        // and the pulses line up with the first cycle of the new level.
        always_comb begin
            db_nxt   = state_is_high(state_nxt);
            rise_nxt = (state == WAIT1) && (state_nxt == ONE);
            fall_nxt = (state == WAIT0) && (state_nxt == ZERO);
        end

        assign db[i]   = db_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

endmodule
